// File: rtl/ac_rle_scheduler.sv
// AC run-length scheduler: turns zigzag-ordered AC coefficients into
// (run, size, amplitude) symbols with ZRL insertion and EOB for trailing zeros.
module ac_rle_scheduler #(
  parameter int COEFF_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coeff_vld,
  input  logic signed [COEFF_W-1:0] coeff,
  output logic                      coeff_rdy,
  output logic                      sym_vld,
  input  logic                      sym_rdy,
  output logic [3:0]                sym_run,
  output logic [3:0]                sym_size,
  output logic [9:0]                sym_amp,
  output logic                      sym_eob,
  output logic                      sym_last
);

  typedef enum logic {S_RUN, S_ZRL} state_t;

  localparam logic signed [COEFF_W-1:0] C_MAX = COEFF_W'(1023);
  localparam logic signed [COEFF_W-1:0] C_MIN = COEFF_W'(-1023);

  state_t      state, state_n;
  logic [5:0]  idx, idx_n;
  logic [5:0]  zcnt, zcnt_n;
  logic [3:0]  hold_size, hold_size_n;
  logic [9:0]  hold_amp, hold_amp_n;
  logic        hold_last, hold_last_n;

  logic        slot_free, accept, is_zero;
  logic        load, ld_eob, ld_last;
  logic [3:0]  ld_run, ld_size;
  logic [9:0]  ld_amp;

  logic signed [COEFF_W-1:0] c_clamp, c_abs;
  logic        c_neg;
  logic [9:0]  c_mag, amp_mask, c_amp;
  logic [3:0]  c_size;

  assign slot_free = !sym_vld || sym_rdy;
  assign coeff_rdy = (state == S_RUN) && slot_free;
  assign accept    = coeff_vld && coeff_rdy;
  assign is_zero   = (coeff == '0);

  // Negative amplitude is the one's complement of |c| within the size field.
  always_comb begin
    if (coeff > C_MAX)      c_clamp = C_MAX;
    else if (coeff < C_MIN) c_clamp = C_MIN;
    else                    c_clamp = coeff;
    c_neg  = c_clamp[COEFF_W-1];
    c_abs  = c_neg ? -c_clamp : c_clamp;
    c_mag  = c_abs[9:0];
    c_size = '0;
    for (int unsigned b = 0; b < 10; b++) begin
      if (c_mag[b]) c_size = 4'(b + 1);
    end
    amp_mask = 10'((11'd1 << c_size) - 11'd1);
    c_amp    = c_neg ? (~c_mag & amp_mask) : c_mag;
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    zcnt_n      = zcnt;
    hold_size_n = hold_size;
    hold_amp_n  = hold_amp;
    hold_last_n = hold_last;
    load        = 1'b0;
    ld_run      = '0;
    ld_size     = '0;
    ld_amp      = '0;
    ld_eob      = 1'b0;
    ld_last     = 1'b0;
    if (state == S_RUN) begin
      if (accept) begin
        idx_n = (idx == 6'd63) ? 6'd1 : idx + 6'd1;
        if (is_zero) begin
          if (idx == 6'd63) begin
            load    = 1'b1;
            ld_eob  = 1'b1;
            ld_last = 1'b1;
            zcnt_n  = '0;
          end else begin
            zcnt_n = zcnt + 6'd1;
          end
        end else if (zcnt < 6'd16) begin
          load    = 1'b1;
          ld_run  = zcnt[3:0];
          ld_size = c_size;
          ld_amp  = c_amp;
          ld_last = (idx == 6'd63);
          zcnt_n  = '0;
        end else begin
          load        = 1'b1;
          ld_run      = 4'd15;
          zcnt_n      = zcnt - 6'd16;
          hold_size_n = c_size;
          hold_amp_n  = c_amp;
          hold_last_n = (idx == 6'd63);
          state_n     = S_ZRL;
        end
      end
    end else if (slot_free) begin
      load = 1'b1;
      if (zcnt >= 6'd16) begin
        ld_run = 4'd15;
        zcnt_n = zcnt - 6'd16;
      end else begin
        ld_run  = zcnt[3:0];
        ld_size = hold_size;
        ld_amp  = hold_amp;
        ld_last = hold_last;
        zcnt_n  = '0;
        state_n = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      idx       <= 6'd1;
      zcnt      <= '0;
      hold_size <= '0;
      hold_amp  <= '0;
      hold_last <= 1'b0;
      sym_vld   <= 1'b0;
      sym_run   <= '0;
      sym_size  <= '0;
      sym_amp   <= '0;
      sym_eob   <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      zcnt      <= zcnt_n;
      hold_size <= hold_size_n;
      hold_amp  <= hold_amp_n;
      hold_last <= hold_last_n;
      sym_vld   <= load || (sym_vld && !sym_rdy);
      if (load) begin
        sym_run  <= ld_run;
        sym_size <= ld_size;
        sym_amp  <= ld_amp;
        sym_eob  <= ld_eob;
        sym_last <= ld_last;
      end
    end
  end

endmodule

// File: tb/tb_ac_rle_scheduler.sv
// Scoreboard bench for ac_rle_scheduler: a block-level reference model queues
// expected symbols; a negedge monitor pops and compares on each handshake.
module tb_ac_rle_scheduler;

  localparam int COEFF_W = 12;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      coeff_vld = 1'b0;
  logic signed [COEFF_W-1:0] coeff = '0;
  logic                      coeff_rdy;
  logic                      sym_vld;
  logic                      sym_rdy = 1'b1;
  logic [3:0]                sym_run, sym_size;
  logic [9:0]                sym_amp;
  logic                      sym_eob, sym_last;

  ac_rle_scheduler #(.COEFF_W(COEFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .coeff_vld(coeff_vld), .coeff(coeff),
    .coeff_rdy(coeff_rdy), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_eob(sym_eob), .sym_last(sym_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] run;
    logic [3:0] size;
    logic [9:0] amp;
    logic       eob;
    logic       last;
  } sym_t;

  sym_t exp_q[$];
  int   blk[63];
  int   stalls[63];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic sym_t mk(int run, int size, int amp, int eob, int last);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(size);
    s.amp  = 10'(amp);
    s.eob  = 1'(eob);
    s.last = 1'(last);
    return s;
  endfunction

  // Reference: walk the block, count zeros, flush ZRLs only before a nonzero.
  task automatic model_block(input int n);
    int run = 0;
    int v, a, sz, amp;
    for (int k = 0; k < n; k++) begin
      v = blk[k];
      if (v > 1023) v = 1023;
      if (v < -1023) v = -1023;
      if (v == 0) begin
        run++;
        if (k == 62) exp_q.push_back(mk(0, 0, 0, 1, 1));
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 0, 0, 0));
          run -= 16;
        end
        a  = (v < 0) ? -v : v;
        sz = 0;
        while ((a >> sz) != 0) sz++;
        amp = (v > 0) ? v : ((v - 1) & ((1 << sz) - 1));
        exp_q.push_back(mk(run, sz, amp, 0, (k == 62) ? 1 : 0));
        run = 0;
      end
    end
  endtask

  task automatic send_block(input int n);
    bit ok;
    int st;
    for (int k = 0; k < n; k++) begin
      coeff_vld = 1'b1;
      coeff     = COEFF_W'(blk[k]);
      st        = 0;
      forever begin
        @(negedge clk);
        ok = coeff_rdy;
        @(posedge clk);
        #1;
        if (ok) break;
        st++;
        if (st > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: coeff %0d not accepted, expected within 300 cycles", k + 1);
          coeff_vld = 1'b0;
          return;
        end
      end
      stalls[k] = st;
    end
    coeff_vld = 1'b0;
  endtask

  task automatic run_block(input int n);
    model_block(n);
    send_block(n);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 63; k++) blk[k] = 0;
  endtask

  task automatic random_blk();
    int r;
    for (int k = 0; k < 63; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      blk[k] = 0;
      else if (r < 90) blk[k] = int'($urandom_range(1, 15)) * (($urandom_range(0, 1) != 0) ? 1 : -1);
      else             blk[k] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  task automatic check_clamp_hold();
    int w = 0;
    @(negedge clk);
    while (!sym_vld && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("clamp_hold_sym", {sym_vld, sym_run, sym_size, sym_amp, sym_eob, sym_last},
          {1'b1, 4'd0, 4'd10, 10'd1023, 1'b0, 1'b0});
      chk("clamp_coeff_rdy", coeff_rdy, 0);
      if (i < 4) @(negedge clk);
    end
    rdy_mode = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       sym_rdy = 1'b1;
        1:       sym_rdy = ($urandom_range(0, 3) != 0);
        default: sym_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: symbol compare on handshake, hold-stability and input stall under backpressure.
  initial begin
    sym_t cur, prev, e;
    bit   prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {sym_run, sym_size, sym_amp, sym_eob, sym_last};
        if (prev_stall) chk("backpressure_hold", {sym_vld, cur}, {1'b1, prev});
        if (sym_vld && !sym_rdy) chk("stall_coeff_rdy", coeff_rdy, 0);
        if (sym_vld && sym_rdy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sym: got %h expected no symbol at %0t", cur, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sym", cur, e);
          end
        end
        prev_stall = sym_vld && !sym_rdy;
        prev       = cur;
      end
    end
  end

  initial begin
    #12;
    chk("reset_out", {sym_vld, sym_run, sym_size, sym_amp, sym_eob, sym_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_reset", coeff_rdy, 1);

    clear_blk();
    blk[0] = 5;
    run_block(63);
    chk("eob_latency", {sym_vld, sym_eob, sym_last}, 3'b111);

    clear_blk();
    blk[0] = -3;
    blk[1] = -1;
    blk[2] = -1023;
    run_block(63);

    clear_blk();
    blk[35] = 7;
    run_block(63);
    chk("zrl_stall_cycles", stalls[36], 2);

    clear_blk();
    blk[62] = -2;
    run_block(63);

    wait_drain();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    clear_blk();
    blk[0] = 2000;
    model_block(63);
    fork
      send_block(63);
      check_clamp_hold();
    join
    random_blk();
    blk[0] = int'($urandom_range(1, 900));
    run_block(63);

    rdy_mode = 1;
    for (int b = 0; b < 6; b++) begin
      random_blk();
      run_block(63);
    end

    wait_drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 19; k++) blk[k] = int'($urandom_range(1, 100));
    run_block(19);
    coeff_vld = 1'b1;
    coeff     = 12'sd5;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_vld", sym_vld, 0);
    chk("async_reset_fields", {sym_run, sym_size, sym_amp, sym_eob, sym_last}, 0);
    chk("partial_block_syms", exp_q.size(), 0);
    coeff_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_blk();
    run_block(63);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
